// File: rtl/load_unit.sv
// load_unit: effective-address load execution with a req/gnt/rvalid memory read and sign/zero-extended writeback
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ld_valid        decoded load present this cycle
//   ld_ready        unit idle and able to accept a load
//   load_control    LB=000 LH=001 LW=010 LBU=100 LHU=101; every other code (LD_NOP=111) is discarded
//   rs1_data, imm   base register and signed 12-bit offset
//   rd              destination register index
//   mem_req         read request, held with mem_addr until mem_gnt
//   mem_addr        word-aligned read address
//   mem_gnt         request accepted
//   mem_rvalid      read data valid (honoured only while waiting for a response)
//   mem_rdata       little-endian read word
//   wb_valid        one-cycle writeback pulse with wb_rd / wb_data
//   ld_err          one-cycle error pulse (response timeout, or misalignment)
//
// Optional feature: define LOAD_MISALIGN_CHECK_EN to reject misaligned LH/LHU/LW
// at accept time without touching memory.
module load_unit #(
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [2:0]  load_control,
    input  logic [31:0] rs1_data,
    input  logic [11:0] imm,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        ld_err
);
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_ea;
    logic [2:0]  r_ctl;
    logic [4:0]  r_rd;
    logic [15:0] r_cnt;
    logic        r_wb_valid, r_err;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic [31:0] w_ea, w_ext;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_accept, w_is_load, w_misalign, w_timeout;

    assign w_ea      = rs1_data + {{20{imm[11]}}, imm};
    assign w_accept  = ld_valid && (r_state == S_IDLE);
    assign w_is_load = load_control inside {LB, LH, LW, LBU, LHU};
    assign w_timeout = (32'(r_cnt) + 32'd1) == RESP_TIMEOUT;

`ifdef LOAD_MISALIGN_CHECK_EN
    assign w_misalign = ((load_control == LH || load_control == LHU) && w_ea[0]) ||
                        (load_control == LW && w_ea[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Lane selection from the latched address; the word itself is always aligned.
    assign w_byte = mem_rdata[{r_ea[1:0], 3'b000} +: 8];
    assign w_half = mem_rdata[{r_ea[1], 4'b0000} +: 16];

    always_comb begin
        w_ext = mem_rdata;
        case (r_ctl)
            LB:      w_ext = {{24{w_byte[7]}}, w_byte};
            LBU:     w_ext = {24'd0, w_byte};
            LH:      w_ext = {{16{w_half[15]}}, w_half};
            LHU:     w_ext = {16'd0, w_half};
            default: w_ext = mem_rdata;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = (w_accept && w_is_load && !w_misalign) ? S_REQ : S_IDLE;
            S_REQ:   w_next = mem_gnt ? S_WAIT : S_REQ;
            S_WAIT:  w_next = mem_rvalid ? S_DONE : (w_timeout ? S_IDLE : S_WAIT);
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ea       <= 32'd0;
            r_ctl      <= 3'd0;
            r_rd       <= 5'd0;
            r_cnt      <= 16'd0;
            r_wb_valid <= 1'b0;
            r_err      <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= 32'd0;
        end else begin
            r_wb_valid <= 1'b0;
            r_err      <= 1'b0;
            // NOP/unknown codes leave every register untouched.
            if (w_accept && w_is_load) begin
                r_ea  <= w_ea;
                r_ctl <= load_control;
                r_rd  <= rd;
                r_err <= w_misalign;
            end
            if (r_state == S_REQ && mem_gnt) r_cnt <= 16'd0;
            if (r_state == S_WAIT) begin
                if (mem_rvalid) begin
                    r_wb_valid <= 1'b1;
                    r_wb_rd    <= r_rd;
                    r_wb_data  <= w_ext;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                    r_err <= w_timeout;
                end
            end
        end
    end

    assign ld_ready = (r_state == S_IDLE);
    assign mem_req  = (r_state == S_REQ);
    assign mem_addr = {r_ea[31:2], 2'b00};
    assign wb_valid = r_wb_valid;
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;
    assign ld_err   = r_err;
endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: randomized and directed checking of load_unit against a transaction-level model
module tb_load_unit;
    localparam int TO = 4;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101, LD_NOP = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid, ld_ready;
    logic [2:0]  load_control;
    logic [31:0] rs1_data;
    logic [11:0] imm;
    logic [4:0]  rd;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ld_err;

    int checks = 0;
    int failures = 0;

    load_unit #(.RESP_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .load_control(load_control), .rs1_data(rs1_data), .imm(imm), .rd(rd),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .ld_err(ld_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] extract(input logic [2:0] c, input logic [31:0] ea, input logic [31:0] w);
        int unsigned sh;
        logic [31:0] v;
        if (c == LW) return w;
        if (c == LB || c == LBU) begin
            sh = 8 * 32'(ea[1:0]);
            v = (w >> sh) & 32'h0000_00FF;
            return (c == LB && v[7]) ? (v | 32'hFFFF_FF00) : v;
        end
        sh = ea[1] ? 16 : 0;
        v = (w >> sh) & 32'h0000_FFFF;
        return (c == LH && v[15]) ? (v | 32'hFFFF_0000) : v;
    endfunction

    function automatic bit is_load(input logic [2:0] c);
        return c inside {LB, LH, LW, LBU, LHU};
    endfunction

    // Transaction-level model: one outstanding load, tracked as "issued / granted / cycles waited".
    bit          have_load = 0, granted = 0, wb_now = 0, e_err = 0;
    int          waited = 0;
    logic [31:0] m_ea = 0, e_addr = 0, e_wb_data = 0;
    logic [2:0]  m_ctl = 0;
    logic [4:0]  m_rd = 0, e_wb_rd = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_load = 0; granted = 0; wb_now = 0; e_err = 0; waited = 0;
            e_addr = 0; e_wb_data = 0; e_wb_rd = 0;
        end else begin
            bit wb_before;
            bit mis;
            wb_before = wb_now;
            wb_now = 0;
            e_err = 0;
            if (have_load && !granted) begin
                if (mem_gnt) begin granted = 1; waited = 0; end
            end else if (have_load) begin
                if (mem_rvalid) begin
                    wb_now = 1;
                    e_wb_rd = m_rd;
                    e_wb_data = extract(m_ctl, m_ea, mem_rdata);
                    have_load = 0;
                end else begin
                    waited++;
                    if (waited >= TO) begin e_err = 1; have_load = 0; end
                end
            end else if (!wb_before && ld_valid && is_load(load_control)) begin
                m_ea = rs1_data + 32'($signed(imm));
                m_ctl = load_control;
                m_rd = rd;
                e_addr = m_ea & 32'hFFFF_FFFC;
                mis = 0;
`ifdef LOAD_MISALIGN_CHECK_EN
                mis = ((m_ctl == LH || m_ctl == LHU) && m_ea[0]) || (m_ctl == LW && m_ea[1:0] != 2'b00);
`endif
                if (mis) e_err = 1;
                else begin have_load = 1; granted = 0; end
            end
        end
    end

    always @(negedge clk) begin
        check("ld_ready", 32'(ld_ready), 32'(!have_load && !wb_now));
        check("mem_req", 32'(mem_req), 32'(have_load && !granted));
        check("mem_addr", mem_addr, e_addr);
        check("wb_valid", 32'(wb_valid), 32'(wb_now));
        check("wb_rd", 32'(wb_rd), 32'(e_wb_rd));
        check("wb_data", wb_data, e_wb_data);
        check("ld_err", 32'(ld_err), 32'(e_err));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one load from IDLE; grant after gd REQ cycles, data in the first WAIT cycle.
    task automatic run_load(input logic [2:0] c, input logic [31:0] rs, input logic [11:0] im,
                            input logic [4:0] r, input logic [31:0] rdat, input int gd,
                            input logic [31:0] exp_addr, input logic [31:0] exp_data);
        ld_valid = 1; load_control = c; rs1_data = rs; imm = im; rd = r;
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        ld_valid = 0;
        for (int i = 0; i <= gd; i++) begin
            mem_gnt = (i == gd);
            @(negedge clk);
            check("lit_req", {30'd0, mem_req, ld_ready}, 32'h2);
            check("lit_addr", mem_addr, exp_addr);
            tick();
        end
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = rdat;
        tick();
        mem_rvalid = 0;
        @(negedge clk);
        check("lit_wb_valid", 32'(wb_valid), 32'h1);
        check("lit_wb_data", wb_data, exp_data);
        check("lit_wb_rd", 32'(wb_rd), 32'(r));
        tick();
    endtask

    initial begin
        rst_n = 0; ld_valid = 0; load_control = LD_NOP; rs1_data = 0; imm = 0; rd = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        check("pin_lb", extract(LB, 32'h0000_1FFF, 32'h80AA_5512), 32'hFFFF_FF80);
        check("pin_lbu", extract(LBU, 32'h0000_1FFF, 32'h80AA_5512), 32'h0000_0080);
        check("pin_lh", extract(LH, 32'h0000_0102, 32'h9ABC_1234), 32'hFFFF_9ABC);
        check("pin_lhu", extract(LHU, 32'h0000_0100, 32'h9ABC_1234), 32'h0000_1234);
        tick(); tick();
        @(negedge clk);
        check("rst_ready", 32'(ld_ready), 32'h1);
        check("rst_outs", {mem_req, wb_valid, ld_err, wb_rd}, 32'h0);
        check("rst_data", wb_data | mem_addr, 32'h0);
        tick();
        rst_n = 1;
        tick();

        run_load(LW, 32'h0000_1000, 12'h004, 5'd7, 32'hDEAD_BEEF, 0, 32'h0000_1004, 32'hDEAD_BEEF);
        run_load(LB, 32'h0000_2000, 12'hFFF, 5'd3, 32'h80AA_5512, 0, 32'h0000_1FFC, 32'hFFFF_FF80);
        run_load(LBU, 32'h0000_2000, 12'hFFF, 5'd3, 32'h80AA_5512, 1, 32'h0000_1FFC, 32'h0000_0080);
        run_load(LH, 32'h0000_0100, 12'h002, 5'd12, 32'h9ABC_1234, 3, 32'h0000_0100, 32'hFFFF_9ABC);
        run_load(LHU, 32'h0000_0100, 12'h002, 5'd0, 32'h9ABC_1234, 0, 32'h0000_0100, 32'h0000_9ABC);

        ld_valid = 1; load_control = LW; rs1_data = 32'h3000; imm = 0; rd = 9; mem_gnt = 1;
        tick();
        ld_valid = 0;
        tick();
        mem_gnt = 0;
        repeat (3) tick();
        @(negedge clk);
        check("to_early", {30'd0, ld_err, ld_ready}, 32'h0);
        tick();
        @(negedge clk);
        check("to_err", {29'd0, ld_err, ld_ready, wb_valid}, 32'h6);
        tick();
        @(negedge clk);
        check("to_once", 32'(ld_err), 32'h0);

        for (int k = 0; k < 2; k++) begin
            tick();
            ld_valid = 1; load_control = (k == 0) ? LD_NOP : 3'b011;
            tick();
            ld_valid = 0;
            @(negedge clk);
            check("nop_quiet", {30'd0, mem_req, ld_ready}, 32'h1);
            check("nop_addr", mem_addr, 32'h0000_3000);
        end
        tick();

        ld_valid = 1; load_control = LW; rs1_data = 32'h4000; imm = 0; rd = 5; mem_gnt = 1;
        tick();
        ld_valid = 0;
        tick();
        mem_gnt = 0;
        tick();
        rst_n = 0;
        @(negedge clk);
        check("rstw_outs", {ld_ready, mem_req, wb_valid, ld_err, wb_rd}, 32'h100);
        check("rstw_data", wb_data | mem_addr, 32'h0);
        tick();
        rst_n = 1; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        tick();
        mem_rvalid = 0;
        @(negedge clk);
        check("rstw_nowb", {30'd0, wb_valid, ld_ready}, 32'h1);
        tick();
        run_load(LW, 32'h0000_5000, 12'h008, 5'd21, 32'hCAFE_F00D, 0, 32'h0000_5008, 32'hCAFE_F00D);

`ifdef LOAD_MISALIGN_CHECK_EN
        ld_valid = 1; load_control = LW; rs1_data = 32'h1000; imm = 12'h002; rd = 4;
        tick();
        ld_valid = 0;
        @(negedge clk);
        check("mis_err", {30'd0, mem_req, ld_err}, 32'h1);
        tick();
        @(negedge clk);
        check("mis_once", 32'(ld_err), 32'h0);
        tick();
`else
        run_load(LW, 32'h0000_1000, 12'h002, 5'd4, 32'h1357_9BDF, 0, 32'h0000_1000, 32'h1357_9BDF);
`endif

        for (int i = 0; i < 4000; i++) begin
            ld_valid = 1'($urandom_range(0, 1));
            load_control = 3'($urandom_range(0, 7));
            rs1_data = $urandom;
            imm = 12'($urandom);
            rd = 5'($urandom);
            mem_gnt = ($urandom_range(0, 1) == 1);
            mem_rvalid = ($urandom_range(0, 99) < 35);
            mem_rdata = $urandom;
            rst_n = ($urandom_range(0, 599) != 0);
            tick();
        end
        rst_n = 1; ld_valid = 0; mem_gnt = 0; mem_rvalid = 0;
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
